// File: rtl/rtc_clock_if.sv
// Time-of-day bus between rtc_clock and its host: control/load inputs, time and strobe outputs.
// Alarm inputs exist only when RTC_ALARM_EN is defined.
interface rtc_clock_if;
    logic       en;
    logic       load;
    logic [5:0] load_sec;
    logic [5:0] load_min;
    logic [4:0] load_hour;
    logic       mode12;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [4:0] hour_disp;
    logic       pm;
    logic       sec_tick;
    logic       min_tick;
    logic       hour_tick;
    logic       day_tick;
    logic       load_err;
    logic       alarm;
`ifdef RTC_ALARM_EN
    logic       alarm_arm;
    logic [5:0] alarm_min;
    logic [4:0] alarm_hour;

    modport master (
        output en, load, load_sec, load_min, load_hour, mode12,
        output alarm_arm, alarm_min, alarm_hour,
        input  sec, min, hour, hour_disp, pm,
        input  sec_tick, min_tick, hour_tick, day_tick, load_err, alarm
    );
    modport slave (
        input  en, load, load_sec, load_min, load_hour, mode12,
        input  alarm_arm, alarm_min, alarm_hour,
        output sec, min, hour, hour_disp, pm,
        output sec_tick, min_tick, hour_tick, day_tick, load_err, alarm
    );
`else
    modport master (
        output en, load, load_sec, load_min, load_hour, mode12,
        input  sec, min, hour, hour_disp, pm,
        input  sec_tick, min_tick, hour_tick, day_tick, load_err, alarm
    );
    modport slave (
        input  en, load, load_sec, load_min, load_hour, mode12,
        output sec, min, hour, hour_disp, pm,
        output sec_tick, min_tick, hour_tick, day_tick, load_err, alarm
    );
`endif
endinterface

// File: rtl/rtc_clock.sv
// hh:mm:ss time-of-day counter with prescaler, validated load, 12/24h display and rollover strobes.
// Optional alarm comparator enabled by defining RTC_ALARM_EN.
module rtc_clock #(
    parameter int TICK_DIV      = 100000000,
    parameter int HOURS_PER_DAY = 24
) (
    input  logic           clk,
    input  logic           rst,
    rtc_clock_if.slave     bus
);
    localparam int             PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [4:0]     HOUR_LAST  = 5'(HOURS_PER_DAY - 1);

    logic [PW-1:0] presc_reg;
    logic [5:0]    sec_reg;
    logic [5:0]    min_reg;
    logic [4:0]    hour_reg;
    logic          sec_tick_reg;
    logic          min_tick_reg;
    logic          hour_tick_reg;
    logic          day_tick_reg;
    logic          load_err_reg;
    logic          alarm_reg;

    logic          load_ok;
    logic          wrap;
    logic          advance;
    logic          sec_wrap;
    logic          min_wrap;
    logic          hour_wrap;
    logic [5:0]    sec_next;
    logic [5:0]    min_next;
    logic [4:0]    hour_next;
    logic          alarm_hit;
    logic [4:0]    hour_disp_next;
    logic          pm_next;

    assign load_ok = (bus.load_sec < 6'd60) && (bus.load_min < 6'd60) && (bus.load_hour <= HOUR_LAST);
    assign wrap    = bus.en && (presc_reg == PRESC_LAST);
    // A rejected load still lets the prescaler run but swallows that cycle's advance.
    assign advance = wrap && !bus.load;

    assign sec_wrap  = (sec_reg == 6'd59);
    assign min_wrap  = sec_wrap && (min_reg == 6'd59);
    assign hour_wrap = min_wrap && (hour_reg == HOUR_LAST);

    assign sec_next  = sec_wrap ? 6'd0 : sec_reg + 6'd1;
    assign min_next  = sec_wrap ? ((min_reg == 6'd59) ? 6'd0 : min_reg + 6'd1) : min_reg;
    assign hour_next = min_wrap ? (hour_wrap ? 5'd0 : hour_reg + 5'd1) : hour_reg;

`ifdef RTC_ALARM_EN
    assign alarm_hit = bus.alarm_arm && (sec_next == 6'd0) &&
                       (min_next == bus.alarm_min) && (hour_next == bus.alarm_hour);
`else
    assign alarm_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg     <= '0;
            sec_reg       <= '0;
            min_reg       <= '0;
            hour_reg      <= '0;
            sec_tick_reg  <= 1'b0;
            min_tick_reg  <= 1'b0;
            hour_tick_reg <= 1'b0;
            day_tick_reg  <= 1'b0;
            load_err_reg  <= 1'b0;
            alarm_reg     <= 1'b0;
        end else begin
            sec_tick_reg  <= 1'b0;
            min_tick_reg  <= 1'b0;
            hour_tick_reg <= 1'b0;
            day_tick_reg  <= 1'b0;
            load_err_reg  <= 1'b0;
            alarm_reg     <= 1'b0;
            if (bus.load && load_ok) begin
                sec_reg   <= bus.load_sec;
                min_reg   <= bus.load_min;
                hour_reg  <= bus.load_hour;
                presc_reg <= '0;
            end else begin
                load_err_reg <= bus.load;
                if (bus.en) begin
                    presc_reg <= wrap ? '0 : presc_reg + PW'(1);
                end
                if (advance) begin
                    sec_reg       <= sec_next;
                    min_reg       <= min_next;
                    hour_reg      <= hour_next;
                    sec_tick_reg  <= 1'b1;
                    min_tick_reg  <= sec_wrap;
                    hour_tick_reg <= min_wrap;
                    day_tick_reg  <= hour_wrap;
                    alarm_reg     <= alarm_hit;
                end
            end
        end
    end

    // Midnight shows as 12 in 12-hour mode; only a 24-hour day has a PM half.
    always_comb begin
        hour_disp_next = hour_reg;
        pm_next        = 1'b0;
        if (bus.mode12) begin
            if (hour_reg == 5'd0) begin
                hour_disp_next = 5'd12;
            end else if (HOURS_PER_DAY == 24 && hour_reg >= 5'd12) begin
                pm_next = 1'b1;
                if (hour_reg > 5'd12) begin
                    hour_disp_next = hour_reg - 5'd12;
                end
            end
        end
    end

    assign bus.sec       = sec_reg;
    assign bus.min       = min_reg;
    assign bus.hour      = hour_reg;
    assign bus.hour_disp = hour_disp_next;
    assign bus.pm        = pm_next;
    assign bus.sec_tick  = sec_tick_reg;
    assign bus.min_tick  = min_tick_reg;
    assign bus.hour_tick = hour_tick_reg;
    assign bus.day_tick  = day_tick_reg;
    assign bus.load_err  = load_err_reg;
    assign bus.alarm     = alarm_reg;
endmodule

// File: tb/tb_rtc_clock.sv
// Randomized bench for rtc_clock: reference model tracks time as seconds-of-day plus a prescaler count.
module tb_rtc_clock;
    localparam int TD  = 4;
    localparam int HPD = 24;
    localparam int DAY = HPD * 3600;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rtc_clock_if bus ();
    rtc_clock #(.TICK_DIV(TD), .HOURS_PER_DAY(HPD)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    // reference state
    int t  = 0;
    int pc = 0;
    bit e_sec_tick, e_min_tick, e_hour_tick, e_day_tick, e_load_err, e_alarm;
    bit arm = 0;
    int am  = 0;
    int ah  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        int h;
        int disp;
        bit pmx;
        h    = t / 3600;
        disp = h;
        pmx  = 1'b0;
        if (bus.mode12) begin
            disp = (h % 12 == 0) ? 12 : h % 12;
            pmx  = (HPD == 24) && (h >= 12);
        end
        check_eq("sec",       32'(bus.sec),       32'(t % 60));
        check_eq("min",       32'(bus.min),       32'((t / 60) % 60));
        check_eq("hour",      32'(bus.hour),      32'(h));
        check_eq("hour_disp", 32'(bus.hour_disp), 32'(disp));
        check_eq("pm",        32'(bus.pm),        32'(pmx));
        check_eq("sec_tick",  32'(bus.sec_tick),  32'(e_sec_tick));
        check_eq("min_tick",  32'(bus.min_tick),  32'(e_min_tick));
        check_eq("hour_tick", 32'(bus.hour_tick), 32'(e_hour_tick));
        check_eq("day_tick",  32'(bus.day_tick),  32'(e_day_tick));
        check_eq("load_err",  32'(bus.load_err),  32'(e_load_err));
        check_eq("alarm",     32'(bus.alarm),     32'(e_alarm));
    endtask

    // One clock: drive inputs, advance the model across the edge, then compare.
    task automatic step(input bit r, input bit e, input bit ld,
                        input int s, input int m, input int h, input bit md);
        bit legal;
        bit adv;
        rst           = r;
        bus.en        = e;
        bus.load      = ld;
        bus.load_sec  = 6'(s);
        bus.load_min  = 6'(m);
        bus.load_hour = 5'(h);
        bus.mode12    = md;
`ifdef RTC_ALARM_EN
        bus.alarm_arm  = arm;
        bus.alarm_min  = 6'(am);
        bus.alarm_hour = 5'(ah);
`endif
        @(posedge clk);
        legal = (s < 60) && (m < 60) && (h < HPD);
        adv   = 1'b0;
        {e_sec_tick, e_min_tick, e_hour_tick, e_day_tick, e_load_err, e_alarm} = '0;
        if (r) begin
            t  = 0;
            pc = 0;
        end else if (ld && legal) begin
            t  = h * 3600 + m * 60 + s;
            pc = 0;
        end else begin
            e_load_err = ld;
            if (e) begin
                if (pc == TD - 1) begin
                    pc  = 0;
                    adv = !ld;
                end else begin
                    pc++;
                end
            end
        end
        if (adv) begin
            t           = (t + 1) % DAY;
            e_sec_tick  = 1'b1;
            e_min_tick  = (t % 60 == 0);
            e_hour_tick = (t % 3600 == 0);
            e_day_tick  = (t == 0);
`ifdef RTC_ALARM_EN
            e_alarm     = arm && (t == ah * 3600 + am * 60);
`endif
        end
        if (ld && !r)
            $display("load %02d:%02d:%02d %s", h, m, s, legal ? "accepted" : "rejected");
        #1;
        compare_all();
    endtask

    int hrs [5] = '{0, 11, 12, 13, 23};
    int dsp [5] = '{12, 11, 12, 1, 11};
    int pmv [5] = '{0, 0, 1, 1, 1};

    initial begin
        int cnt;
        step(1, 0, 0, 0, 0, 0, 0);
        check_eq("reset_sec", 32'(bus.sec), 32'd0);
        check_eq("reset_disp24", 32'(bus.hour_disp), 32'd0);
        step(1, 0, 0, 0, 0, 0, 1);
        check_eq("reset_disp12", 32'(bus.hour_disp), 32'd12);

        // first advance exactly TICK_DIV enabled cycles after reset
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0);
        check_eq("t1_no_early_tick", 32'(bus.sec_tick), 32'd0);
        step(0, 1, 0, 0, 0, 0, 0);
        check_eq("t1_sec1", 32'(bus.sec), 32'd1);
        check_eq("t1_tick", 32'(bus.sec_tick), 32'd1);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0, 0);
        check_eq("t1_sec3", 32'(bus.sec), 32'd3);

        // full carry chain across midnight
        step(0, 1, 1, 58, 59, 23, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0, 0);
        check_eq("t2_hms", {bus.hour, bus.min, bus.sec}, 32'd0);
        check_eq("t2_ticks", {bus.sec_tick, bus.min_tick, bus.hour_tick, bus.day_tick}, 32'hF);

        // illegal load is rejected
        step(0, 0, 1, 3, 2, 1, 0);
        step(0, 0, 1, 60, 2, 1, 0);
        check_eq("t3_err", 32'(bus.load_err), 32'd1);
        check_eq("t3_sec", 32'(bus.sec), 32'd3);
        step(0, 1, 0, 0, 0, 0, 0);
        check_eq("t3_err_clear", 32'(bus.load_err), 32'd0);

        // load coincident with prescaler wrap
        step(0, 1, 1, 10, 10, 10, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 20, 20, 10, 0);
        check_eq("t4_load_wins", 32'(bus.sec), 32'd20);
        check_eq("t4_no_tick", 32'(bus.sec_tick), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0);
        check_eq("t4_next_adv", 32'(bus.sec), 32'd21);
        step(1, 1, 1, 5, 5, 5, 0);
        check_eq("t4_rst_over_load", {bus.hour, bus.min, bus.sec}, 32'd0);

        // 12-hour display table
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, 0, hrs[i], 1);
            check_eq("t5_disp", 32'(bus.hour_disp), 32'(dsp[i]));
            check_eq("t5_pm", 32'(bus.pm), 32'(pmv[i]));
        end

`ifdef RTC_ALARM_EN
        arm = 1; am = 30; ah = 7;
        step(0, 1, 1, 59, 29, 7, 0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0, 0, 0, 0);
            if (bus.alarm) cnt++;
        end
        check_eq("t6_alarm_once", 32'(cnt), 32'd1);
        step(0, 1, 1, 0, 30, 7, 0);
        check_eq("t6_load_no_alarm", 32'(bus.alarm), 32'd0);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, e, ld, md;
            int s, m, h;
            r  = ($urandom_range(0, 499) == 0);
            e  = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 24) == 0);
            md = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) begin
                s = $urandom_range(55, 59); m = 59; h = $urandom_range(HPD - 2, HPD - 1);
            end else begin
                s = $urandom_range(0, 63); m = $urandom_range(0, 63); h = $urandom_range(0, 31);
            end
`ifdef RTC_ALARM_EN
            if (ld) begin
                arm = $urandom_range(0, 1);
                am  = (m + 1) % 60;
                ah  = (m == 59) ? (h + 1) % HPD : h;
            end
`endif
            step(r, e, ld, s, m, h, md);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rtc_clock.md
Name: rtc_clock

Overview:
Parametrised time-of-day counter (hh:mm:ss) for the timing subsystem. It is the successor to the free-running per-clock seconds counter and adds:
- an internal prescaler, so time advances once per TICK_DIV clocks;
- an enable input;
- validated time load;
- 12/24-hour display mode;
- single-cycle rollover strobes.
Feeds display drivers and event schedulers.

Parameters:
TICK_DIV, 100000000, clk cycles per second; must be >= 2. Prescaler width = clog2(TICK_DIV).
HOURS_PER_DAY, 24, hour wrap value; legal values 12 or 24. Internal hour range is 0..HOURS_PER_DAY-1.

Ports:
clk        in   1  system clock, all logic on rising edge
rst        in   1  synchronous, active-high reset
en         in   1  count enable; 0 freezes prescaler and time
load       in   1  one-cycle request to load time
load_sec   in   6  seconds to load, legal 0..59
load_min   in   6  minutes to load, legal 0..59
load_hour  in   5  hours to load, legal 0..HOURS_PER_DAY-1
mode12     in   1  1 = 12-hour display on hour_disp/pm
sec        out  6  current seconds (registered)
min        out  6  current minutes (registered)
hour       out  5  current hours, internal 0-based form (registered)
hour_disp  out  5  display hour (combinational from hour, mode12)
pm         out  1  PM flag (combinational)
sec_tick   out  1  1-cycle pulse, seconds advanced
min_tick   out  1  1-cycle pulse, minutes advanced
hour_tick  out  1  1-cycle pulse, hours advanced
day_tick   out  1  1-cycle pulse, hours wrapped to 0
load_err   out  1  1-cycle pulse, load rejected
alarm      out  1  alarm pulse (see Optional Feature)

Behaviour:
- Clock and reset: single clock domain, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - sec, min, hour = 0; prescaler = 0.
  - all tick pulses, load_err and alarm = 0.
  - hour_disp = 12 if mode12 else 0; pm = 0.
- Priority per edge: rst > load > en counting.
- Prescaler:
  - When en=1 and no load, it increments.
  - On reaching TICK_DIV-1 it returns to 0 and the time advances by one second on that same edge. First advance occurs TICK_DIV enabled cycles after reset or a valid load.
- Advance:
  - sec 59 -> 0 carries to min; min 59 -> 0 carries to hour.
  - hour HOURS_PER_DAY-1 -> 0 asserts day_tick.
  - A full carry chain from 59:59 sets all affected fields in one edge.
- Tick pulses:
  - Registered; high for exactly the one cycle in which outputs first show the new value.
  - sec_tick fires on every advance. min_tick, hour_tick and day_tick fire only on the corresponding carry; they may coincide.
- Load:
  - If all three load fields are legal: fields are written, prescaler cleared to 0, no tick pulses that cycle.
  - If any field is illegal: time and prescaler are unchanged (the prescaler still counts if en=1, but the advance is suppressed that cycle), and load_err pulses one cycle.
  - Load works with en=0.
- en=0: time, prescaler and pulses hold at 0/steady. Deasserting en mid-second preserves the prescaler count.
- Display:
  - mode12=0: hour_disp = hour, pm = 0.
  - mode12=1, HOURS_PER_DAY=24:
    - hour 0 -> 12, pm=0
    - 1..11 -> same, pm=0
    - 12 -> 12, pm=1
    - 13..23 -> hour-12, pm=1
  - mode12=1, HOURS_PER_DAY=12: hour 0 -> 12, else hour; pm = 0.
- Arithmetic: all compares are unsigned at field width; no out-of-range value is ever reachable.

Optional Feature:
Macro RTC_ALARM_EN.
- Defined: adds inputs alarm_arm (1), alarm_min (6), alarm_hour (5). When alarm_arm=1 and an advance produces min==alarm_min, hour==alarm_hour, sec==0, alarm pulses for one cycle, aligned with sec_tick. Loads never trigger alarm.
- Undefined: the extra inputs are absent and alarm is tied to 0.

Test Plan:
1. TICK_DIV=4, reset then en=1 -> sec reaches 1 with sec_tick=1 exactly 4 cycles after rst falls; sec=3 after 12 cycles.
2. Load 23:59:58 (HOURS_PER_DAY=24), en=1 -> after 8 cycles time = 00:00:00; sec_tick, min_tick, hour_tick and day_tick all pulse on the same cycle.
3. Load sec=60 while at 01:02:03 -> load_err=1 for one cycle; time stays 01:02:03 and continues normally.
4. load and prescaler wrap on the same edge -> loaded value wins, no sec_tick, next advance 4 cycles later; rst asserted together with load -> all zeros.
5. mode12=1: hours 0, 11, 12, 13, 23 -> hour_disp/pm = 12/0, 11/0, 12/1, 1/1, 11/1.
6. RTC_ALARM_EN: arm at 07:30, load 07:29:59 -> alarm pulses once with the 07:30:00 sec_tick. Load 07:30:00 directly -> no alarm.
